spi_ram_bridge: RTL and testbench

SPI_RAM_BRIDGE -- requirements
Module: spi_ram_bridge

---
 rtl/nrfice_pkg.sv | 16 +
 rtl/spi_ram_bridge_if.sv | 13 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_ram_bridge.sv | 173 +++++++++++++++++
 tb/tb_spi_ram_bridge.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nrfice_pkg.sv
// Shared command codes and FSM state encoding for the SPI-to-RAM bridge.
package nrfice_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WR_DATA,
        RD_DATA,
        DISCARD
    } state_t;

endpackage

// File: rtl/spi_ram_bridge_if.sv
// RAM-side bus of the bridge: word address, write data/strobe, access enable, read data.
interface spi_ram_bridge_if;

    logic [7:0]  addr_o;
    logic [15:0] wr_data_o;
    logic        wr_en_o;
    logic        clk_en_o;
    logic [15:0] rd_data_i;

    modport master (output addr_o, wr_data_o, wr_en_o, clk_en_o, input rd_data_i);
    modport slave  (input addr_o, wr_data_o, wr_en_o, clk_en_o, output rd_data_i);

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin with rise/fall detection
// taken from the synchronised level.
module spi_sync_edge #(
    parameter int STAGES   = 2,
    parameter bit IDLE_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync <= {STAGES{IDLE_VAL}};
            prev <= IDLE_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            prev <= sync[STAGES-1];
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_ram_bridge.sv
// SPI mode-0 slave that turns write (0x02) / read (0x03) frames into single-cycle
// accesses on a 16-bit word RAM with auto-incrementing 8-bit address.
//
// state   | meaning
// IDLE    | waiting for a fresh cs_n fall
// CMD     | shifting in the command byte
// ADDR    | shifting in the start address byte
// WR_DATA | assembling 16-bit words, one RAM write per word
// RD_DATA | shifting prefetched words out on miso
// DISCARD | illegal command, ignore bits until cs_n rises
module spi_ram_bridge
    import nrfice_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RD_LATENCY  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sclk_i,
    input  logic             cs_n_i,
    input  logic             mosi_i,
    output logic             miso_o,
    output logic             frame_err_o,
    spi_ram_bridge_if.master ram
);

    localparam logic [1:0] RD_WAIT    = 2'(RD_LATENCY);
    localparam logic [1:0] SETTLE_CNT = 2'(SYNC_STAGES);

    logic sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sclk (
        .clock(clock), .reset(reset), .din(sclk_i),
        .level(), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_cs (
        .clock(clock), .reset(reset), .din(cs_n_i),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_mosi (
        .clock(clock), .reset(reset), .din(mosi_i),
        .level(mosi_lvl), .rise(), .fall()
    );

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [14:0] shift_in;
    logic [15:0] shift_out;
    logic        is_read;
    logic        rd_busy;
    logic [1:0]  rd_cnt;
    logic [1:0]  settle;
    logic        armed;
    logic [7:0]  byte_in;
    logic [15:0] word_in;

    assign byte_in = {shift_in[6:0], mosi_lvl};
    assign word_in = {shift_in, mosi_lvl};

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift_in      <= '0;
            shift_out     <= '0;
            is_read       <= 1'b0;
            rd_busy       <= 1'b0;
            rd_cnt        <= '0;
            settle        <= '0;
            armed         <= 1'b0;
            ram.addr_o    <= '0;
            ram.wr_data_o <= '0;
            ram.wr_en_o   <= 1'b0;
            ram.clk_en_o  <= 1'b0;
            miso_o        <= 1'b0;
            frame_err_o   <= 1'b0;
        end else begin
            ram.wr_en_o  <= 1'b0;
            ram.clk_en_o <= 1'b0;
            frame_err_o  <= 1'b0;

            // A cs_n already low when reset is released must not look like a frame start.
            if (settle != SETTLE_CNT) settle <= settle + 2'd1;
            else if (cs_lvl)          armed  <= 1'b1;

            // Post-increment after a write so the strobe cycle carries the word's own address.
            if (ram.wr_en_o) ram.addr_o <= ram.addr_o + 8'd1;

            if (rd_busy) begin
                if (rd_cnt == 2'd0) begin
                    shift_out <= ram.rd_data_i;
                    rd_busy   <= 1'b0;
                end else begin
                    rd_cnt <= rd_cnt - 2'd1;
                end
            end

            if (sclk_rise) shift_in <= {shift_in[13:0], mosi_lvl};

            if (state != IDLE && cs_rise) begin
                state       <= IDLE;
                miso_o      <= 1'b0;
                rd_busy     <= 1'b0;
                bit_cnt     <= '0;
                frame_err_o <= (state == ADDR) || (state != DISCARD && bit_cnt != 4'd0);
            end else begin
                case (state)
                    IDLE: begin
                        miso_o  <= 1'b0;
                        bit_cnt <= '0;
                        if (cs_fall && armed) state <= CMD;
                    end
                    CMD: if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            if (byte_in == CMD_WRITE || byte_in == CMD_READ) begin
                                state   <= ADDR;
                                is_read <= (byte_in == CMD_READ);
                            end else begin
                                state       <= DISCARD;
                                frame_err_o <= 1'b1;
                            end
                        end
                    end
                    ADDR: if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt    <= '0;
                            ram.addr_o <= byte_in;
                            if (is_read) begin
                                state        <= RD_DATA;
                                ram.clk_en_o <= 1'b1;
                                rd_busy      <= 1'b1;
                                rd_cnt       <= RD_WAIT;
                            end else begin
                                state <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            ram.wr_data_o <= word_in;
                            ram.wr_en_o   <= 1'b1;
                            ram.clk_en_o  <= 1'b1;
                        end
                    end
                    RD_DATA: begin
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd15) begin
                                ram.addr_o   <= ram.addr_o + 8'd1;
                                ram.clk_en_o <= 1'b1;
                                rd_busy      <= 1'b1;
                                rd_cnt       <= RD_WAIT;
                            end
                        end
                        if (sclk_fall) begin
                            miso_o    <= shift_out[15];
                            shift_out <= {shift_out[14:0], 1'b0};
                        end
                    end
                    DISCARD: miso_o <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Bench for spi_ram_bridge: two instances (read latency 1 and 2) driven by one SPI
// master, each with its own RAM model, checked against a frame-level reference model.
module tb_spi_ram_bridge;
    import nrfice_pkg::*;

    localparam int HALF = 6;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic sclk  = 1'b0;
    logic cs_n  = 1'b1;
    logic mosi  = 1'b0;

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        tx [512];
    logic        rx [2][512];
    int          tx_len;
    logic [15:0] ref_mem [256];

    function automatic logic [15:0] init_word(input int i);
        if (i == 'h10) return 16'hAAA3;
        return 16'(i * 40503) ^ 16'h5A5A;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic        miso, ferr;
        logic [15:0] mem [256];
        logic [15:0] pipe1 = '0;
        logic [15:0] pipe2 = '0;
        int          wr_n = 0, rd_n = 0, ferr_n = 0, viol_n = 0;
        logic [7:0]  wr_a [64];
        logic [15:0] wr_d [64];

        spi_ram_bridge_if bus ();

        spi_ram_bridge #(.SYNC_STAGES(g + 2), .RD_LATENCY(g + 1)) dut (
            .clock(clock), .reset(reset), .sclk_i(sclk), .cs_n_i(cs_n), .mosi_i(mosi),
            .miso_o(miso), .frame_err_o(ferr), .ram(bus)
        );

        assign bus.rd_data_i = (g == 0) ? pipe1 : pipe2;

        initial for (int i = 0; i < 256; i++) mem[i] = init_word(i);

        always @(posedge clock) begin
            if (bus.clk_en_o && bus.wr_en_o) mem[bus.addr_o] <= bus.wr_data_o;
            else if (bus.clk_en_o)           pipe1 <= mem[bus.addr_o];
            pipe2 <= pipe1;
        end

        always @(negedge clock) begin
            if (bus.clk_en_o && bus.wr_en_o) begin
                if (wr_n < 64) begin
                    wr_a[wr_n] = bus.addr_o;
                    wr_d[wr_n] = bus.wr_data_o;
                end
                wr_n++;
            end
            if (bus.clk_en_o && !bus.wr_en_o) rd_n++;
            if (bus.wr_en_o && !bus.clk_en_o) viol_n++;
            if (ferr) ferr_n++;
        end
    end

    function automatic int cnt_wr(input int g);
        return (g == 0) ? g_dut[0].wr_n : g_dut[1].wr_n;
    endfunction
    function automatic int cnt_rd(input int g);
        return (g == 0) ? g_dut[0].rd_n : g_dut[1].rd_n;
    endfunction
    function automatic int cnt_fe(input int g);
        return (g == 0) ? g_dut[0].ferr_n : g_dut[1].ferr_n;
    endfunction
    function automatic logic [23:0] wr_log(input int g, input int k);
        if (g == 0) return {g_dut[0].wr_a[k], g_dut[0].wr_d[k]};
        return {g_dut[1].wr_a[k], g_dut[1].wr_d[k]};
    endfunction
    function automatic logic [31:0] outs(input int g);
        if (g == 0)
            return {4'd0, g_dut[0].bus.addr_o, g_dut[0].bus.wr_data_o, g_dut[0].bus.wr_en_o,
                    g_dut[0].bus.clk_en_o, g_dut[0].miso, g_dut[0].ferr};
        return {4'd0, g_dut[1].bus.addr_o, g_dut[1].bus.wr_data_o, g_dut[1].bus.wr_en_o,
                g_dut[1].bus.clk_en_o, g_dut[1].miso, g_dut[1].ferr};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [31:0] val, input int nb);
        for (int i = nb - 1; i >= 0; i--) begin
            tx[tx_len] = val[i];
            tx_len++;
        end
    endtask

    function automatic logic [15:0] bits_at(input int pos, input int nb);
        logic [15:0] v = '0;
        for (int i = 0; i < nb; i++) v = {v[14:0], tx[pos + i]};
        return v;
    endfunction

    task automatic clock_bits(input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clock);
            rx[0][i] = g_dut[0].miso;
            rx[1][i] = g_dut[1].miso;
            sclk = 1'b1;
            repeat (HALF) @(negedge clock);
            sclk = 1'b0;
        end
    endtask

    task automatic end_frame();
        repeat (HALF) @(negedge clock);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (4 * HALF) @(negedge clock);
    endtask

    // Frame-level reference: legality, strobes, write log, error pulses and miso stream.
    task automatic run_and_check(input int nbits, input string tag);
        int          wr0 [2], rd0 [2], fe0 [2];
        logic [7:0]  cmd, a;
        logic        legal, rd;
        int          nwords, exp_wr, exp_rd, exp_fe, w, nb;
        logic [15:0] got, exp, word;
        for (int g = 0; g < 2; g++) begin
            wr0[g] = cnt_wr(g); rd0[g] = cnt_rd(g); fe0[g] = cnt_fe(g);
        end
        cs_n = 1'b0;
        repeat (HALF) @(negedge clock);
        clock_bits(0, nbits);
        end_frame();

        cmd    = 8'(bits_at(0, 8));
        a      = 8'(bits_at(8, 8));
        legal  = (nbits >= 8) && (cmd == CMD_WRITE || cmd == CMD_READ);
        rd     = legal && (cmd == CMD_READ);
        nwords = (nbits >= 16) ? (nbits - 16) / 16 : 0;
        if (nbits < 8)   exp_fe = (nbits > 0) ? 1 : 0;
        else if (!legal) exp_fe = 1;
        else             exp_fe = (nbits < 16 || (nbits - 16) % 16 != 0) ? 1 : 0;
        exp_wr = (legal && !rd) ? nwords : 0;
        exp_rd = (rd && nbits >= 16) ? nwords + 1 : 0;

        for (int g = 0; g < 2; g++) begin
            check($sformatf("%s_wr_count_d%0d", tag, g), 32'(cnt_wr(g) - wr0[g]), 32'(exp_wr));
            check($sformatf("%s_rd_count_d%0d", tag, g), 32'(cnt_rd(g) - rd0[g]), 32'(exp_rd));
            check($sformatf("%s_ferr_pulses_d%0d", tag, g), 32'(cnt_fe(g) - fe0[g]), 32'(exp_fe));
            for (int k = 0; k < exp_wr; k++)
                check($sformatf("%s_write%0d_d%0d", tag, k, g), 32'(wr_log(g, wr0[g] + k)),
                      32'({8'(a + 8'(k)), bits_at(16 + 16 * k, 16)}));
            for (int c = 0; c * 16 < nbits; c++) begin
                got = '0; exp = '0;
                nb  = (nbits - c * 16 < 16) ? nbits - c * 16 : 16;
                for (int j = 0; j < nb; j++) begin
                    got = {got[14:0], rx[g][c * 16 + j]};
                    if (rd && c >= 1) begin
                        w    = c - 1;
                        word = ref_mem[8'(a + 8'(w))];
                        exp  = {exp[14:0], word[15 - j]};
                    end else begin
                        exp = {exp[14:0], 1'b0};
                    end
                end
                check($sformatf("%s_miso_chunk%0d_d%0d", tag, c, g), 32'(got), 32'(exp));
            end
        end
        for (int k = 0; k < exp_wr; k++) ref_mem[8'(a + 8'(k))] = bits_at(16 + 16 * k, 16);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int         sel, words, trunc, nbits;
        int         wr0 [2], rd0 [2], fe0 [2];
        int         ones;
        logic [7:0] rcmd;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        repeat (3) @(negedge clock);
        check("reset_outs_d0", outs(0), 32'd0);
        check("reset_outs_d1", outs(1), 32'd0);
        reset = 1'b0;
        repeat (8) @(negedge clock);

        tx_len = 0; put(8'h03, 8); put(8'h10, 8); put(16'h0, 16); put(16'h0, 16);
        run_and_check(48, "read_0x10");

        tx_len = 0; put(8'h02, 8); put(8'h10, 8); put(16'hBEEF, 16);
        run_and_check(32, "write_beef");

        tx_len = 0; put(8'h02, 8); put(8'hFF, 8); put(16'h1111, 16); put(16'h2222, 16);
        run_and_check(48, "burst_wrap");

        tx_len = 0; put(8'h03, 8); put(8'hFF, 8); put(16'h0, 16); put(16'h0, 16);
        run_and_check(48, "read_wrap");

        tx_len = 0; put(8'h55, 8); put(8'h10, 8); put(16'hFFFF, 16);
        run_and_check(32, "bad_cmd");

        tx_len = 0; put(8'h02, 8); put(8'h20, 8); put(16'hFFFF, 16);
        run_and_check(25, "abort_9bits");

        tx_len = 0; put(8'h02, 8); put(8'h20, 8); put(16'h1234, 16);
        run_and_check(32, "write_after_abort");

        tx_len = 0; put(8'h03, 8); put(8'h20, 8); put(16'h0, 16);
        run_and_check(20, "read_partial");

        for (int f = 0; f < 8; f++) begin
            sel   = $urandom_range(0, 4);
            rcmd  = (sel < 2) ? CMD_WRITE : (sel < 4) ? CMD_READ : 8'($urandom);
            words = $urandom_range(1, 3);
            trunc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
            nbits = 16 + 16 * words + trunc;
            tx_len = 0;
            put(32'(rcmd), 8);
            put($urandom, 8);
            for (int k = 0; k <= words; k++) put($urandom, 16);
            run_and_check(nbits, $sformatf("rand%0d", f));
        end

        // Reset in the middle of a read burst, with cs_n still low afterwards.
        tx_len = 0; put(8'h03, 8); put(8'h40, 8);
        for (int k = 0; k < 3; k++) put($urandom, 16);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clock);
        clock_bits(0, 40);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_outs_d0", outs(0), 32'd0);
        check("midrst_outs_d1", outs(1), 32'd0);
        for (int g = 0; g < 2; g++) begin
            wr0[g] = cnt_wr(g); rd0[g] = cnt_rd(g); fe0[g] = cnt_fe(g);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        clock_bits(40, 64);
        end_frame();
        for (int g = 0; g < 2; g++) begin
            ones = 0;
            for (int i = 40; i < 64; i++) if (rx[g][i] !== 1'b0) ones++;
            check($sformatf("midrst_miso_d%0d", g), 32'(ones), 32'd0);
            check($sformatf("midrst_rd_count_d%0d", g), 32'(cnt_rd(g) - rd0[g]), 32'd0);
            check($sformatf("midrst_wr_count_d%0d", g), 32'(cnt_wr(g) - wr0[g]), 32'd0);
            check($sformatf("midrst_ferr_d%0d", g), 32'(cnt_fe(g) - fe0[g]), 32'd0);
        end

        tx_len = 0; put(8'h03, 8); put(8'h40, 8); put(16'h0, 16);
        run_and_check(32, "read_after_reset");

        check("wr_without_clk_en_d0", 32'(g_dut[0].viol_n), 32'd0);
        check("wr_without_clk_en_d1", 32'(g_dut[1].viol_n), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
